// File: rtl/issue_pkg.sv
// issue_pkg: shared state type and one-hot decode helper
// for the issue select arbiter.
package issue_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_e;

   localparam int MAXW = 64;

   function automatic logic [5:0] onehot2idx(
      input logic [MAXW-1:0] i_oh
   );
      logic [5:0] v_idx;
      v_idx = '0;
      for (int i = 0; i < MAXW; i++) begin
         if (i_oh[i]) v_idx = v_idx | 6'(i);
      end
      return v_idx;
   endfunction

endpackage

// File: rtl/issue_age_matrix.sv
// issue_age_matrix: relative age of issue slots and
// oldest-eligible winner selection.
module issue_age_matrix
   import issue_pkg::*;
#(
   parameter  int DEPTH = 16,
   parameter  int LANES = 4,
   localparam int IDXW  = $clog2(DEPTH)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [LANES-1:0]      i_alloc_v,
   input  logic [LANES*IDXW-1:0] i_alloc_idx,
   input  logic [DEPTH-1:0]      i_keep,
   input  logic [DEPTH-1:0]      i_elig,
   output logic [DEPTH-1:0]      o_alloc,
   output logic [DEPTH-1:0]      o_win
);

   // r_age[j][i] set: slot j is older than slot i
   logic [DEPTH-1:0][DEPTH-1:0] r_age;
   // w_pair[j][i] set: j took an earlier lane than i
   logic [DEPTH-1:0][DEPTH-1:0] w_pair;
   logic [IDXW-1:0]             w_lidx [LANES];
   logic                        w_dup;
   logic                        w_blk;

   // Split the packed lane indices
   always_comb begin
      for (int n = 0; n < LANES; n++) begin
         w_lidx[n] = i_alloc_idx[n*IDXW +: IDXW];
      end
   end

   // Alloc mask, same-cycle lane order, duplicate detect
   always_comb begin
      o_alloc = '0;
      w_pair  = '0;
      w_dup   = 1'b0;
      for (int n = 0; n < LANES; n++) begin
         if (i_alloc_v[n]) o_alloc[w_lidx[n]] = 1'b1;
      end
      for (int m = 0; m < LANES; m++) begin
         for (int n = m + 1; n < LANES; n++) begin
            if (i_alloc_v[m] && i_alloc_v[n]) begin
               w_pair[w_lidx[m]][w_lidx[n]] = 1'b1;
               if (w_lidx[m] == w_lidx[n]) w_dup = 1'b1;
            end
         end
      end
   end

   // New slot: its row holds only later lanes, its
   // column marks every surviving occupant as older
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_age <= '0;
      end else begin
         for (int j = 0; j < DEPTH; j++) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (o_alloc[j])
                  r_age[j][i] <= w_pair[j][i];
               else if (o_alloc[i])
                  r_age[j][i] <= i_keep[j];
            end
         end
      end
   end

   // A slot wins when no older slot is eligible
   always_comb begin
      o_win = '0;
      w_blk = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         w_blk = 1'b0;
         for (int j = 0; j < DEPTH; j++) begin
            w_blk = w_blk | (i_elig[j] & r_age[j][i]);
         end
         o_win[i] = i_elig[i] & ~w_blk;
      end
   end

   a_no_dup_alloc: assert property (
      @(posedge i_clk) disable iff (i_rst) !w_dup
   );

endmodule

// File: rtl/issue_select.sv
// issue_select: oldest-first single-port issue arbiter.
// Optional ISSUE_SELECT_PERF_EN adds perf counters.
module issue_select
   import issue_pkg::*;
#(
   parameter  int DEPTH = 16,
   parameter  int LANES = 4,
   localparam int IDXW  = $clog2(DEPTH)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [LANES-1:0]      i_alloc_v,
   input  logic [LANES*IDXW-1:0] i_alloc_idx,
   input  logic [DEPTH-1:0]      i_req,
   input  logic [DEPTH-1:0]      i_kill,
   input  logic                  i_ready,
   output logic                  o_valid,
   output logic [DEPTH-1:0]      o_grant,
   output logic [IDXW-1:0]       o_idx
`ifdef ISSUE_SELECT_PERF_EN
   ,
   output logic [31:0]           o_perf_issued,
   output logic [31:0]           o_perf_stall
`endif
);

   state_e           r_state;
   logic [DEPTH-1:0] r_occ;
   logic [DEPTH-1:0] r_grant;
   logic [IDXW-1:0]  r_idx;

   logic             w_hs;
   logic             w_any;
   logic [DEPTH-1:0] w_fire;
   logic [DEPTH-1:0] w_keep;
   logic [DEPTH-1:0] w_elig;
   logic [DEPTH-1:0] w_alloc;
   logic [DEPTH-1:0] w_win;
   logic [IDXW-1:0]  w_win_idx;

   assign o_valid   = (r_state == HOLD);
   assign o_grant   = r_grant;
   assign o_idx     = r_idx;

   assign w_hs      = o_valid & i_ready;
   assign w_fire    = w_hs ? r_grant : '0;
   assign w_keep    = r_occ & ~(w_fire | i_kill);
   assign w_elig    = i_req & r_occ & ~i_kill & ~w_fire;
   assign w_any     = |w_elig;
   assign w_win_idx = IDXW'(onehot2idx(MAXW'(w_win)));

   issue_age_matrix #(
      .DEPTH (DEPTH),
      .LANES (LANES)
   ) u_age (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_alloc_v   (i_alloc_v),
      .i_alloc_idx (i_alloc_idx),
      .i_keep      (w_keep),
      .i_elig      (w_elig),
      .o_alloc     (w_alloc),
      .o_win       (w_win)
   );

   // Occupancy: alloc beats a same-cycle issue or kill
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_occ <= '0;
      else       r_occ <= w_alloc | w_keep;
   end

   // Grant FSM: a stalled grant is held unless killed
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_grant <= '0;
         r_idx   <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_state <= HOLD;
                  r_grant <= w_win;
                  r_idx   <= w_win_idx;
               end
            end
            HOLD: begin
               if (i_ready || i_kill[r_idx]) begin
                  if (w_any) begin
                     r_grant <= w_win;
                     r_idx   <= w_win_idx;
                  end else begin
                     r_state <= IDLE;
                     r_grant <= '0;
                     r_idx   <= '0;
                  end
               end
            end
         endcase
      end
   end

`ifdef ISSUE_SELECT_PERF_EN
   logic [31:0] r_issued;
   logic [31:0] r_stall;

   // Handshake and stall counters, wrapping
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_issued <= '0;
         r_stall  <= '0;
      end else begin
         r_issued <= r_issued + 32'(w_hs);
         r_stall  <= r_stall + 32'(o_valid & ~i_ready);
      end
   end

   assign o_perf_issued = r_issued;
   assign o_perf_stall  = r_stall;
`endif

endmodule

// File: tb/tb_issue_select.sv
// tb_issue_select: directed and constrained-random bench
// for issue_select against a timestamp age model.
`timescale 1ns/1ps
module tb_issue_select;

   localparam int DEPTH = 16;
   localparam int LANES = 4;
   localparam int IDXW  = 4;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [LANES-1:0]      alloc_v;
   logic [LANES*IDXW-1:0] alloc_idx;
   logic [DEPTH-1:0]      req;
   logic [DEPTH-1:0]      kill;
   logic                  ready;
   logic                  o_valid;
   logic [DEPTH-1:0]      o_grant;
   logic [IDXW-1:0]       o_idx;
`ifdef ISSUE_SELECT_PERF_EN
   logic [31:0]           perf_issued;
   logic [31:0]           perf_stall;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   issue_select #(
      .DEPTH (DEPTH),
      .LANES (LANES)
   ) u_dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_alloc_v     (alloc_v),
      .i_alloc_idx   (alloc_idx),
      .i_req         (req),
      .i_kill        (kill),
      .i_ready       (ready),
      .o_valid       (o_valid),
      .o_grant       (o_grant),
      .o_idx         (o_idx)
`ifdef ISSUE_SELECT_PERF_EN
      ,
      .o_perf_issued (perf_issued),
      .o_perf_stall  (perf_stall)
`endif
   );

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h @%0t",
                  name, act, exp, $time);
      end
   endtask

   // Model: each slot carries an alloc timestamp;
   // the oldest eligible slot has the smallest stamp.
   bit          m_occ   [DEPTH];
   int unsigned m_stamp [DEPTH];
   int unsigned m_seq;
   bit          m_valid;
   int          m_idx;
   int unsigned m_iss;
   int unsigned m_stall;
   bit          c_hs, c_any, c_e, c_pv;
   int          c_win, c_pidx, c_k;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            m_occ[i]   = 1'b0;
            m_stamp[i] = 0;
         end
         m_seq   = 0;
         m_valid = 1'b0;
         m_idx   = 0;
         m_iss   = 0;
         m_stall = 0;
      end else begin
         c_pv   = m_valid;
         c_pidx = m_idx;
         c_hs   = m_valid && ready;
         c_any  = 1'b0;
         c_win  = 0;
         for (int i = 0; i < DEPTH; i++) begin
            c_e = req[i] && m_occ[i] && !kill[i]
                  && !(c_hs && i == c_pidx);
            if (c_e && (!c_any
                || m_stamp[i] < m_stamp[c_win])) begin
               c_any = 1'b1;
               c_win = i;
            end
         end
         if (!c_pv || ready || kill[c_pidx]) begin
            m_valid = c_any;
            m_idx   = c_any ? c_win : 0;
         end
         if (c_hs) m_iss++;
         if (c_pv && !ready) m_stall++;
         for (int i = 0; i < DEPTH; i++) begin
            if ((c_hs && i == c_pidx) || kill[i])
               m_occ[i] = 1'b0;
         end
         for (int n = 0; n < LANES; n++) begin
            if (alloc_v[n]) begin
               c_k = int'(alloc_idx[n*IDXW +: IDXW]);
               m_occ[c_k]   = 1'b1;
               m_stamp[c_k] = m_seq;
               m_seq++;
            end
         end
      end
      #1;
      check("m_valid", 32'(o_valid), 32'(m_valid));
      if (m_valid) begin
         check("m_idx", 32'(o_idx), 32'(m_idx));
         check("m_grant", 32'(o_grant), 32'(1) << m_idx);
      end
`ifdef ISSUE_SELECT_PERF_EN
      check("m_issued", perf_issued, m_iss);
      check("m_stall", perf_stall, m_stall);
`endif
   end

   task automatic idle_in();
      alloc_v   = '0;
      alloc_idx = '0;
      req       = '0;
      kill      = '0;
      ready     = 1'b0;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic set_lane(input int n, input int s);
      alloc_v[n] = 1'b1;
      alloc_idx[n*IDXW +: IDXW] = IDXW'(s);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_in();
      step();
      step();
      rst = 1'b0;
   endtask

   bit t_used [DEPTH];
   int t_s;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_in();
      rst = 1'b1;
      step();
      step();
      check("rst_valid", 32'(o_valid), 0);
      check("rst_grant", 32'(o_grant), 0);
      check("rst_idx", 32'(o_idx), 0);
`ifdef ISSUE_SELECT_PERF_EN
      check("rst_issued", perf_issued, 0);
      check("rst_stall", perf_stall, 0);
`endif
      rst = 1'b0;

      // Oldest first, back to back
      set_lane(0, 3);
      set_lane(1, 1);
      step();
      idle_in();
      req   = '1;
      ready = 1'b1;
      step();
      check("t1_v", 32'(o_valid), 1);
      check("t1_first", 32'(o_idx), 3);
      step();
      check("t1_second", 32'(o_idx), 1);
      check("t1_grant", 32'(o_grant), 32'h2);
      step();
      check("t1_done", 32'(o_valid), 0);

      // Stalled grant is not re-arbitrated
      do_reset();
      set_lane(0, 2);
      set_lane(1, 5);
      step();
      idle_in();
      req = 16'h0020;
      step();
      check("t2_g5", 32'(o_idx), 5);
      req = 16'h0024;
      repeat (3) begin
         step();
         check("t2_hold", 32'(o_idx), 5);
      end
      step();
      check("t2_hold", 32'(o_idx), 5);
      ready = 1'b1;
      step();
      check("t2_next", 32'(o_idx), 2);
      step();
      check("t2_idle", 32'(o_valid), 0);
`ifdef ISSUE_SELECT_PERF_EN
      check("t2_stall", perf_stall, 4);
      check("t2_issued", perf_issued, 2);
`endif

      // Kill of the held grant
      do_reset();
      set_lane(0, 7);
      step();
      idle_in();
      req = 16'h0080;
      step();
      check("t3_g7", 32'(o_idx), 7);
      kill = 16'h0080;
      step();
      check("t3_kill", 32'(o_valid), 0);
      kill  = '0;
      ready = 1'b1;
      repeat (3) begin
         step();
         check("t3_never", 32'(o_valid), 0);
      end

      // Re-alloc during its own handshake
      do_reset();
      set_lane(0, 0);
      set_lane(1, 4);
      step();
      idle_in();
      req   = 16'h0001;
      ready = 1'b1;
      step();
      check("t4_g0", 32'(o_idx), 0);
      check("t4_v0", 32'(o_valid), 1);
      set_lane(0, 0);
      step();
      check("t4_gap", 32'(o_valid), 0);
      alloc_v = '0;
      req     = 16'h0011;
      step();
      check("t4_old", 32'(o_idx), 4);
      step();
      check("t4_young", 32'(o_idx), 0);
      step();
      check("t4_done", 32'(o_valid), 0);

      // Full queue, grants in alloc order
      do_reset();
      for (int c = 0; c < 4; c++) begin
         idle_in();
         for (int n = 0; n < LANES; n++) begin
            set_lane(n, ((4 * c + n) * 5) % 16);
         end
         step();
      end
      idle_in();
      req   = '1;
      ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         step();
         check("t5_v", 32'(o_valid), 1);
         check("t5_order", 32'(o_idx), 32'((k * 5) % 16));
      end
      step();
      check("t5_done", 32'(o_valid), 0);

      // Reset mid-grant
      do_reset();
      set_lane(0, 9);
      step();
      idle_in();
      req = 16'h0200;
      step();
      check("t6_g9", 32'(o_idx), 9);
      step();
`ifdef ISSUE_SELECT_PERF_EN
      check("t6_stall1", perf_stall, 1);
`endif
      rst = 1'b1;
      #1;
      check("t6_valid", 32'(o_valid), 0);
      check("t6_grant", 32'(o_grant), 0);
`ifdef ISSUE_SELECT_PERF_EN
      check("t6_issued0", perf_issued, 0);
      check("t6_stall0", perf_stall, 0);
`endif
      idle_in();
      step();
      rst = 1'b0;

      // Random traffic against the model
      for (int cyc = 0; cyc < 300; cyc++) begin
         idle_in();
         for (int i = 0; i < DEPTH; i++) t_used[i] = m_occ[i];
         for (int n = 0; n < LANES; n++) begin
            if ($urandom_range(1, 0) == 1) begin
               t_s = int'($urandom_range(DEPTH - 1, 0));
               if (!t_used[t_s]) begin
                  t_used[t_s] = 1'b1;
                  set_lane(n, t_s);
               end
            end
         end
         req = DEPTH'($urandom);
         if ($urandom_range(7, 0) == 0)
            kill = DEPTH'(1) << $urandom_range(DEPTH - 1, 0);
         ready = 1'($urandom_range(1, 0));
         step();
      end
      idle_in();
      step();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
